// File: rtl/stream_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux4
//  Purpose  : Packet-aware 1-to-4 stream demultiplexer. The destination
//             channel is sampled on the first beat of each packet and held
//             until that packet's last beat is accepted. Each output channel
//             has one registered slot (data/last/valid), so channels drain
//             independently of one another.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             s_data     - input beat data [DW]
//             s_valid    - input beat present
//             s_last     - input beat ends its packet
//             s_ready    - input beat accepted when high with s_valid
//             sel        - destination channel, used on packet start only
//             m_data     - output data, channel k at [k*DW +: DW]
//             m_valid    - per-channel output beat present [4]
//             m_last     - per-channel last-beat flag [4]
//             m_ready    - per-channel downstream accept [4]
//             busy       - a multi-beat packet is mid-route
//             cur_sel    - currently locked channel
//             pkt_count  - completed packets, all channels, wraps at 16 bits
//  Revision : 1.0  initial release
// ============================================================================
module stream_demux4 #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [1:0]        sel,
    output logic [4*DW-1:0]   m_data,
    output logic [3:0]        m_valid,
    output logic [3:0]        m_last,
    input  logic [3:0]        m_ready,
    output logic              busy,
    output logic [1:0]        cur_sel,
    output logic [15:0]       pkt_count
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ROUTE = 1'b1;

    logic [0:0]    r_state;
    logic [1:0]    r_lock_sel;
    logic [15:0]   r_pkt_count;
    logic [DW-1:0] r_data [4];
    logic [3:0]    r_valid;
    logic [3:0]    r_last;

    logic [1:0]    w_ch;
    logic          w_accept;
    logic [3:0]    w_load;

    // On a packet's first beat sel steers directly; afterwards the locked
    // channel is used so that sel changes mid-packet have no effect.
    assign w_ch = (r_state == c_ROUTE) ? r_lock_sel : sel;

    // A slot can take a new beat when empty or when it is being drained in
    // this same cycle. Held low during reset so nothing is accepted.
    assign s_ready  = ~rst & (~r_valid[w_ch] | m_ready[w_ch]);
    assign w_accept = s_valid & s_ready;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_ch
            assign w_load[k]             = w_accept & (w_ch == 2'(k));
            assign m_data[k*DW +: DW]    = r_data[k];
        end
    endgenerate

    // Packet routing state and completed-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_lock_sel  <= 2'd0;
            r_pkt_count <= 16'd0;
        end else if (w_accept) begin
            if (r_state == c_IDLE) begin
                r_lock_sel <= sel;
                if (!s_last) begin
                    r_state <= c_ROUTE;
                end
            end else if (s_last) begin
                r_state <= c_IDLE;
            end
            if (s_last) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    // Output slots: a load wins over a drain, which keeps valid high and
    // replaces the contents when a slot is emptied and refilled together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'd0;
            r_last  <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k]  <= s_data;
                    r_last[k]  <= s_last;
                    r_valid[k] <= 1'b1;
                end else if (r_valid[k] && m_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign m_valid   = r_valid;
    assign m_last    = r_last;
    assign busy      = (r_state == c_ROUTE);
    assign cur_sel   = r_lock_sel;
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_demux4
//  Purpose  : Directed, self-checking bench for stream_demux4. Accepted
//             beats are pushed to per-channel expected queues; a monitor
//             pops and compares them as each channel transfers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_demux4;

    localparam int DW = 16;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [1:0]      sel;
    logic [4*DW-1:0] m_data;
    logic [3:0]      m_valid;
    logic [3:0]      m_last;
    logic [3:0]      m_ready;
    logic            busy;
    logic [1:0]      cur_sel;
    logic [15:0]     pkt_count;

    stream_demux4 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .sel       (sel),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .cur_sel   (cur_sel),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t q [4][$];

    int    errors = 0;
    int    checks = 0;
    bit    sb_en  = 1'b1;

    // Reference routing model
    bit          mdl_busy = 1'b0;
    logic [1:0]  mdl_lock = 2'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [1:0] s, input logic [DW-1:0] d, input logic l);
        logic [1:0] ch;
        beat_t b;
        ch = mdl_busy ? mdl_lock : s;
        if (!mdl_busy) begin
            mdl_lock = s;
            mdl_busy = !l;
        end else if (l) begin
            mdl_busy = 1'b0;
        end
        b.d = d;
        b.l = l;
        if (sb_en) q[ch].push_back(b);
    endtask

    // Drive one beat starting just after a rising edge; returns just after
    // the edge that accepted it. waited = cycles spent stalled.
    task automatic send(input logic [1:0] s, input logic [DW-1:0] d, input logic l,
                        output int waited);
        sel = s; s_data = d; s_last = l; s_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(s, d, l);
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
            waited++;
            @(posedge clk); #1;
        end
        errors++;
        $error("FAIL send_timeout observed=stalled expected=accept");
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < 4; k++) q[k].delete();
        mdl_busy = 1'b0;
        mdl_lock = 2'd0;
    endtask

    // Scoreboard monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (m_valid[k] && m_ready[k]) begin
                    check($sformatf("sb_expected_ch%0d", k), 64'(q[k].size() > 0), 64'd1);
                    if (q[k].size() > 0) begin
                        beat_t e;
                        e = q[k].pop_front();
                        check($sformatf("sb_data_ch%0d", k), 64'(m_data[k*DW +: DW]), 64'(e.d));
                        check($sformatf("sb_last_ch%0d", k), 64'(m_last[k]), 64'(e.l));
                    end
                end
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; sel = 2'd0; m_ready = 4'h0;

        // Reset state
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_pkt_count", 64'(pkt_count), 64'h0);
        check("rst_s_ready", 64'(s_ready), 64'h0);
        check("rst_cur_sel", 64'(cur_sel), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Single-beat packet to channel 2 with no downstream accept
        send(2'd2, 16'hA5A5, 1'b1, w);
        @(negedge clk);
        check("single_m_valid", 64'(m_valid), 64'b0100);
        check("single_data2", 64'(m_data[2*DW +: DW]), 64'hA5A5);
        check("single_last2", 64'(m_last[2]), 64'h1);
        check("single_busy", 64'(busy), 64'h0);
        check("single_pkt_count", 64'(pkt_count), 64'h1);
        @(posedge clk); #1;
        m_ready = 4'hF;
        idle(2);

        // 3-beat packet to channel 1, sel moves to 3 after the first beat
        send(2'd1, 16'h1111, 1'b0, w);
        @(negedge clk);
        check("route_busy_b1", 64'(busy), 64'h1);
        check("route_cur_sel_b1", 64'(cur_sel), 64'h1);
        @(posedge clk); #1;
        send(2'd3, 16'h2222, 1'b0, w);
        @(negedge clk);
        check("route_busy_b2", 64'(busy), 64'h1);
        check("route_cur_sel_b2", 64'(cur_sel), 64'h1);
        @(posedge clk); #1;
        send(2'd3, 16'h3333, 1'b1, w);
        @(negedge clk);
        check("route_busy_end", 64'(busy), 64'h0);
        check("route_cur_sel_end", 64'(cur_sel), 64'h1);
        check("route_pkt_count", 64'(pkt_count), 64'h2);
        @(posedge clk); #1;
        idle(2);

        // Backpressure on channel 0, then drain with same-cycle reload
        m_ready = 4'h0;
        send(2'd0, 16'h0B01, 1'b1, w);
        sel = 2'd0; s_data = 16'h0B02; s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        check("bp_s_ready_stalled", 64'(s_ready), 64'h0);
        check("bp_hold_data0", 64'(m_data[0 +: DW]), 64'h0B01);
        @(posedge clk); #1;
        m_ready = 4'b0001;
        @(negedge clk);
        check("bp_s_ready_drain", 64'(s_ready), 64'h1);
        model_accept(2'd0, 16'h0B02, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 4'h0;
        @(negedge clk);
        check("bp_reload_valid0", 64'(m_valid[0]), 64'h1);
        check("bp_reload_data0", 64'(m_data[0 +: DW]), 64'h0B02);
        @(posedge clk); #1;
        m_ready = 4'hF;
        idle(2);

        // Channel 3 stalled and full; channel 0 traffic flows past it
        m_ready = 4'b0111;
        send(2'd3, 16'h3C3C, 1'b1, w);
        send(2'd0, 16'h0A01, 1'b0, w);
        check("indep_wait_b1", 64'(w), 64'h0);
        send(2'd0, 16'h0A02, 1'b1, w);
        check("indep_wait_b2", 64'(w), 64'h0);
        @(negedge clk);
        check("indep_valid3", 64'(m_valid[3]), 64'h1);
        check("indep_data3", 64'(m_data[3*DW +: DW]), 64'h3C3C);
        check("indep_last3", 64'(m_last[3]), 64'h1);
        @(posedge clk); #1;
        m_ready = 4'hF;
        idle(3);
        for (int k = 0; k < 4; k++)
            check($sformatf("sb_empty_ch%0d", k), 64'(q[k].size()), 64'h0);

        // Reset during beat 2 of a 4-beat packet
        m_ready = 4'h0;
        send(2'd1, 16'h4001, 1'b0, w);
        sel = 2'd1; s_data = 16'h4002; s_last = 1'b0; s_valid = 1'b1;
        rst = 1'b1;
        flush_model();
        @(negedge clk);
        check("mid_rst_m_valid", 64'(m_valid), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_pkt_count", 64'(pkt_count), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        send(2'd2, 16'h5555, 1'b1, w);
        @(negedge clk);
        check("post_rst_m_valid", 64'(m_valid), 64'b0100);
        check("post_rst_data2", 64'(m_data[2*DW +: DW]), 64'h5555);
        check("post_rst_pkt_count", 64'(pkt_count), 64'h1);
        @(posedge clk); #1;
        m_ready = 4'hF;
        idle(2);

        // Counter wrap: 65535 single-beat packets then one more
        rst = 1'b1;
        sb_en = 1'b0;
        flush_model();
        idle(1);
        rst = 1'b0;
        sel = 2'd0; s_data = 16'h0001; s_last = 1'b1; s_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("wrap_preload", 64'(pkt_count), 64'hFFFF);
        @(posedge clk); #1;
        send(2'd1, 16'h0002, 1'b1, w);
        @(negedge clk);
        check("wrap_zero", 64'(pkt_count), 64'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
